shared_adder_arbiter: RTL
=========================

Name: shared_adder_arbiter

Overview:
Shares one unsigned 19+19-bit ripple-block carry look-ahead adder among NREQ requesters. Each requester uses a valid/ready handshake. Arbitration is round-robin. The sum is returned in a single registered response slot tagged with the requester index. The block sits between the operand-producing clients and the combinational adder, giving one sum per cycle at full throughput.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 19, operand width; the sum is WIDTH+1 bits
IDW, $clog2(NREQ), requester-index width (derived; not overridable)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  bit i: requester i presents operands
req_ready  output  NREQ  bit i: requester i's operands are accepted this cycle (one-hot or zero)
req_x  input  NREQ*WIDTH  operand X; requester i at bits [i*WIDTH +: WIDTH]
req_y  input  NREQ*WIDTH  operand Y; same packing as req_x
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer accepts the response
rsp_sum  output  WIDTH+1  X+Y, zero-extended, carry-out in MSB
rsp_id  output  IDW  index of the requester that produced rsp_sum
busy_cnt  output  16  number of cycles with rsp_valid=1 and rsp_ready=0; saturates at 0xFFFF

Behaviour:
- Reset (rst=1 at the edge):
  - state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, busy_cnt=0.
  - Any pending result is discarded, including a reset mid-hold.
  - req_ready=0 while rst=1.
- State machine, two states:
  - EMPTY: slot free, rsp_valid=0.
  - FULL: slot holds a result, rsp_valid=1.
- Accept enable: can_accept = (state==EMPTY) | rsp_ready. Draining and refilling in the same cycle is allowed, which gives 1 op/cycle throughput.
- Grant:
  - When can_accept and any req_valid, grant the first asserted requester scanning from rr_ptr upward, modulo NREQ.
  - req_ready[g]=1 for that requester only. req_ready is combinational from req_valid, state, rsp_ready and rr_ptr.
  - There is no combinational path from req_x/req_y to req_ready.
- On a grant (handshake on g):
  - rsp_sum <= {1'b0,X}+{1'b0,Y}, computed by the adder core.
  - rsp_id <= g; state <= FULL; rr_ptr <= (g+1) mod NREQ.
- Without a grant:
  - FULL and rsp_ready=1 → EMPTY.
  - FULL and rsp_ready=0 → hold; rsp_sum and rsp_id stay stable; busy_cnt increments (saturating).
  - rr_ptr is unchanged.
- Latency: handshake in cycle n produces rsp_valid in cycle n+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1 and each requester waits at most NREQ-1 grants.
- Stability: req_valid may drop without a handshake; the requester loses nothing and the pointer does not move.
- Arithmetic:
  - Unsigned, no overflow; the carry-out appears in rsp_sum[WIDTH].
  - Maximum result: 0x7FFFF+0x7FFFF = 0xFFFFE.
- Operands are sampled only on the handshake cycle.

Decomposition:
- Package shared_adder_pkg:
  - WIDTH default, IDW function.
  - State enum {EMPTY, FULL}.
  - Operand-slice helper function.
- Sub-module shared_adder_core: purely combinational WIDTH+WIDTH → WIDTH+1 ripple-block carry look-ahead adder.
  - Four-bit look-ahead blocks.
  - Block carries rippled between groups.
  - Carry-in tied to 0.
  - Instantiated once; the arbiter muxes the granted operands into it.
- Arbiter logic (round-robin priority scan, rr_ptr, slot register, busy_cnt) stays in the top module.

Test Plan:
- Single request: after reset, req_valid=0b0001, X=5, Y=7, rsp_ready=1 → req_ready=0b0001 the same cycle; next cycle rsp_valid=1, rsp_sum=12, rsp_id=0.
- Carry-out: requester 2, X=0x7FFFF, Y=0x7FFFF → rsp_sum=0xFFFFE, rsp_id=2; X=0x7FFFF, Y=1 → rsp_sum=0x80000.
- Round-robin: all four valid continuously, rsp_ready=1, distinct operands → one grant per cycle, order 0,1,2,3,0; rsp_id follows with 1-cycle lag; no bubbles.
- Backpressure: result in slot, rsp_ready=0 for 3 cycles with req_valid=0b1111 → req_ready=0; rsp_sum/rsp_id unchanged; busy_cnt +3. Raise rsp_ready → drain and a new grant in the same cycle.
- Reset mid-hold: FULL with rsp_ready=0, assert rst one cycle → next cycle rsp_valid=0, rr_ptr=0, busy_cnt=0; the first post-reset grant goes to the lowest valid index.
- Pointer/skip: rr_ptr=3, req_valid=0b0110 → grant 1, then rr_ptr=2 and the next grant goes to 2.

Source files
------------

// File: rtl/shared_adder_pkg.sv
// Shared definitions for the round-robin shared adder: slot states, widths and
// the operand-bus slicing helper.
package shared_adder_pkg;

    localparam int unsigned WidthDefault = 19;

    typedef enum logic {
        StEmpty,
        StFull
    } slot_state_e;

    function automatic int unsigned idw_of(int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // Lowest bit of requester idx's operand inside a packed operand bus.
    function automatic int unsigned op_lsb(int unsigned idx, int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shared_adder_core.sv
// Combinational unsigned adder: 4-bit carry look-ahead blocks with the block
// carries rippled from group to group, carry-in tied to zero.
module shared_adder_core #(
    parameter int unsigned WIDTH = 19
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    // Always at least one pad bit so the carry-out slice below is never empty.
    localparam int unsigned NumBlk = WIDTH / 4 + 1;
    localparam int unsigned PadW   = NumBlk * 4;

    logic [PadW-1:0] a_pad, b_pad, gen, prop;
    logic [PadW:0]   carry;
    logic            unused_carry;

    assign a_pad = PadW'(a_i);
    assign b_pad = PadW'(b_i);
    assign gen   = a_pad & b_pad;
    assign prop  = a_pad ^ b_pad;

    always_comb begin
        logic term;
        logic prod;
        carry = '0;
        term  = 1'b0;
        prod  = 1'b0;
        for (int b = 0; b < NumBlk; b++) begin
            for (int k = 1; k <= 4; k++) begin
                // c[k] = (P[k-1:0] & cin) | sum_j (G[j] & P[k-1:j+1]), flat per block
                term = carry[4*b];
                for (int j = 0; j < k; j++) begin
                    term = term & prop[4*b+j];
                end
                for (int j = 0; j < k; j++) begin
                    prod = gen[4*b+j];
                    for (int m = j + 1; m < k; m++) begin
                        prod = prod & prop[4*b+m];
                    end
                    term = term | prod;
                end
                carry[4*b+k] = term;
            end
        end
    end

    assign sum_o        = {carry[WIDTH], prop[WIDTH-1:0] ^ carry[WIDTH-1:0]};
    assign unused_carry = ^carry[PadW:WIDTH+1];

endmodule

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ valid/ready requesters, with a
// single registered response slot tagged by requester index.
module shared_adder_arbiter
    import shared_adder_pkg::*;
#(
    parameter int unsigned  NREQ  = 4,
    parameter int unsigned  WIDTH = WidthDefault,
    localparam int unsigned IDW   = idw_of(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           busy_cnt
);

    slot_state_e     state_q, state_d;
    logic [WIDTH:0]  sum_q, sum_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [15:0]     busy_q, busy_d;

    logic            can_accept, grant_vld, fire;
    logic [IDW-1:0]  grant_idx;
    logic [WIDTH-1:0] x_arr [NREQ];
    logic [WIDTH-1:0] y_arr [NREQ];
    logic [WIDTH-1:0] x_mux, y_mux;
    logic [WIDTH:0]  core_sum;

    // A full slot can be drained and refilled in the same cycle.
    assign can_accept = (state_q == StEmpty) || rsp_ready;

    always_comb begin : grant_scan
        int unsigned idx;
        logic [IDW-1:0] idx_w;
        idx       = 0;
        idx_w     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = 32'(rr_q) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IDW'(idx);
            if (!grant_vld && req_valid[idx_w]) begin
                grant_vld = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    assign fire = !rst && can_accept && grant_vld;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign x_arr[gi] = req_x[op_lsb(gi, WIDTH) +: WIDTH];
        assign y_arr[gi] = req_y[op_lsb(gi, WIDTH) +: WIDTH];
    end

    assign x_mux = x_arr[grant_idx];
    assign y_mux = y_arr[grant_idx];

    shared_adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i   (x_mux),
        .b_i   (y_mux),
        .sum_o (core_sum)
    );

    always_comb begin : next_state
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        if (fire) begin
            state_d = StFull;
            sum_d   = core_sum;
            id_d    = grant_idx;
            rr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (state_q == StFull) begin
            if (rsp_ready) begin
                state_d = StEmpty;
            end else if (busy_q != 16'hFFFF) begin
                busy_d = busy_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            sum_q   <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy_cnt  = busy_q;

endmodule
